// File: rtl/rc_divider_8bit_pkg.sv
// rc_div_pkg: shared types and constants for the 8-bit restoring divider.
// SIGNED_DIV_EN enables two's-complement mode across the slice.
package rc_div_pkg;

    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement magnitude; 8'h80 maps to 128 unsigned.
    function automatic logic [WIDTH-1:0] mag(
        input logic [WIDTH-1:0] x,
        input logic             sgn
    );
        return (sgn && x[WIDTH-1]) ? (~x + 8'd1) : x;
    endfunction

endpackage

// File: rtl/rc_divider_8bit_if.sv
// rc_divider_8bit_if: start/done handshake and result bus.
// is_signed is present only when SIGNED_DIV_EN is defined.
interface rc_divider_8bit_if;
    import rc_div_pkg::*;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef SIGNED_DIV_EN
    logic             is_signed;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             V;

    modport master (
`ifdef SIGNED_DIV_EN
        output is_signed,
`endif
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero,
        input  V
    );

    modport slave (
`ifdef SIGNED_DIV_EN
        input  is_signed,
`endif
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero,
        output V
    );

endinterface

// File: rtl/rc_divider_8bit_step.sv
// rc_div_step: one restoring-division step on a 9-bit ripple subtractor.
// Carry-out of T + ~D + 1 set means no borrow, so the quotient bit is 1.
module rc_div_step
    import rc_div_pkg::*;
(
    input  logic [WIDTH-1:0] r_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_out,
    output logic             q_bit
);

    logic [WIDTH:0]   t;
    logic [WIDTH:0]   b;
    logic [WIDTH-1:0] d;
    logic [WIDTH+1:0] c;

    // Ripple-carry trial subtract, then restore on borrow.
    always_comb begin
        t    = {r_in, q_msb};
        b    = ~{1'b0, divisor};
        d    = '0;
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            if (i < WIDTH) begin
                d[i] = t[i] ^ b[i] ^ c[i];
            end
            c[i+1] = (t[i] & b[i]) | (c[i] & (t[i] ^ b[i]));
        end
        q_bit = c[WIDTH+1];
        r_out = q_bit ? d : t[WIDTH-1:0];
    end

endmodule

// File: rtl/rc_divider_8bit.sv
// rc_divider_8bit: iterative restoring divider, one quotient bit per clock.
// SIGNED_DIV_EN adds is_signed with magnitude division and sign fix-up.
module rc_divider_8bit
    import rc_div_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    rc_divider_8bit_if.slave bus
);

    state_t           state;
    logic [2:0]       cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic             ovf;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             dz;
    logic             v_q;

    logic             sgn;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] r_nxt;
    logic             qb;
    logic [WIDTH-1:0] q_nxt;

    rc_div_step u_step (
        .r_in    (r_q),
        .q_msb   (q_q[WIDTH-1]),
        .divisor (dvs),
        .r_out   (r_nxt),
        .q_bit   (qb)
    );

    // Operand conditioning at the moment a start is accepted.
    always_comb begin
`ifdef SIGNED_DIV_EN
        sgn = bus.is_signed;
`else
        sgn = 1'b0;
`endif
        a_mag = mag(bus.dividend, sgn);
        b_mag = mag(bus.divisor, sgn);
        q_nxt = {q_q[WIDTH-2:0], qb};
    end

    // Control FSM, shift registers and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            r_q   <= '0;
            q_q   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ovf   <= 1'b0;
            quot  <= '0;
            rem   <= '0;
            dz    <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        dz  <= 1'b0;
                        v_q <= 1'b0;
                        if (bus.divisor == '0) begin
                            state <= DONE;
                            quot  <= DIV0_QUOTIENT;
                            rem   <= bus.dividend;
                            dz    <= 1'b1;
                        end else begin
                            state <= RUN;
                            cnt   <= 3'd7;
                            r_q   <= '0;
                            q_q   <= a_mag;
                            dvs   <= b_mag;
                            neg_q <= sgn &
                                (bus.dividend[WIDTH-1] ^
                                 bus.divisor[WIDTH-1]);
                            neg_r <= sgn & bus.dividend[WIDTH-1];
                            ovf   <= sgn &
                                (bus.dividend == 8'h80) &
                                (bus.divisor == 8'hFF);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    r_q <= r_nxt;
                    q_q <= q_nxt;
                    if (cnt == 3'd0) begin
                        state <= DONE;
                        quot  <= neg_q ? (~q_nxt + 8'd1) : q_nxt;
                        rem   <= neg_r ? (~r_nxt + 8'd1) : r_nxt;
                        v_q   <= ovf;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quot;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dz;
    assign bus.V           = v_q;

endmodule
